// File: rtl/ps2_scan_history_if.sv
// rtl/ps2_scan_history_if.sv - PS/2 line inputs and decoded-code/status bundle
interface ps2_scan_history_if #(
  parameter int DEPTH = 8
);
  localparam int EW = $clog2(DEPTH + 1);

  logic               ps2clk;
  logic               ps2data;
  logic               err_clr;
  logic [7:0]         code;
  logic               code_valid;
  logic               is_break;
  logic               is_ext;
  logic [8*DEPTH-1:0] history;
  logic [EW-1:0]      entries;
  logic               frame_err;
  logic               timeout;
  logic               err_sticky;

  modport master (
    input  ps2clk, ps2data, err_clr,
    output code, code_valid, is_break, is_ext, history, entries,
           frame_err, timeout, err_sticky
  );

  modport slave (
    output ps2clk, ps2data, err_clr,
    input  code, code_valid, is_break, is_ext, history, entries,
           frame_err, timeout, err_sticky
  );
endinterface

// File: rtl/ps2_scan_history.sv
// rtl/ps2_scan_history.sv - system-clocked PS/2 receiver with frame checks and code history
module ps2_scan_history #(
  parameter int DEPTH          = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter bit DROP_BREAK     = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  ps2_scan_history_if.master   bus
);
  localparam int HW = 8 * DEPTH;
  localparam int EW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t          state, state_nxt;
  logic [1:0]      ck_s, dt_s;
  logic            filt, samp, samp_d;
  logic [FW-1:0]   flt_cnt;
  logic [10:0]     frame;
  logic [3:0]      bit_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            brk_p, ext_p;
  logic            tmo_hit, frame_ok, err_set;
  logic [7:0]      rx_byte;

  logic [7:0]      code_q;
  logic            code_valid_q, is_break_q, is_ext_q;
  logic [HW-1:0]   history_q;
  logic [EW-1:0]   entries_q;
  logic            frame_err_q, timeout_q, err_sticky_q;

  // Sample event is registered on the same edge the filtered clock drops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ck_s    <= 2'b11;
      dt_s    <= 2'b11;
      filt    <= 1'b1;
      flt_cnt <= '0;
      samp    <= 1'b0;
      samp_d  <= 1'b0;
    end else begin
      ck_s <= {ck_s[0], bus.ps2clk};
      dt_s <= {dt_s[0], bus.ps2data};
      samp <= 1'b0;
      if (ck_s[1] != filt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          filt    <= ck_s[1];
          flt_cnt <= '0;
          samp    <= filt;
          samp_d  <= dt_s[1];
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign rx_byte  = frame[8:1];
  assign frame_ok = ~frame[0] & (^frame[9:1]) & frame[10];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE:  if (samp) state_nxt = RECV;
      RECV: begin
        if (samp) begin
          if (bit_cnt == 4'd10) state_nxt = CHECK;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = IDLE;
          tmo_hit   = 1'b1;
          err_set   = 1'b1;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        err_set   = ~frame_ok;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame        <= '0;
      bit_cnt      <= '0;
      tmo_cnt      <= '0;
      brk_p        <= 1'b0;
      ext_p        <= 1'b0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      is_break_q   <= 1'b0;
      is_ext_q     <= 1'b0;
      history_q    <= '0;
      entries_q    <= '0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= err_set;
      timeout_q    <= tmo_hit;
      if (err_set)          err_sticky_q <= 1'b1;
      else if (bus.err_clr) err_sticky_q <= 1'b0;

      if (samp && state != CHECK) begin
        frame   <= {samp_d, frame[10:1]};
        bit_cnt <= (state == IDLE) ? 4'd1 : bit_cnt + 4'd1;
      end

      if (state == RECV && !samp) tmo_cnt <= tmo_cnt + 1'b1;
      else                        tmo_cnt <= '0;

      if (tmo_hit) begin
        brk_p <= 1'b0;
        ext_p <= 1'b0;
      end

      if (state == CHECK) begin
        if (!frame_ok) begin
          brk_p <= 1'b0;
          ext_p <= 1'b0;
        end else if (rx_byte == 8'hE0) begin
          ext_p <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk_p <= 1'b1;
        end else begin
          brk_p <= 1'b0;
          ext_p <= 1'b0;
          if (!(DROP_BREAK && brk_p)) begin
            code_q       <= rx_byte;
            is_break_q   <= brk_p;
            is_ext_q     <= ext_p;
            code_valid_q <= 1'b1;
            history_q    <= (history_q << 8) | HW'(rx_byte);
            if (entries_q != EW'(DEPTH)) entries_q <= entries_q + 1'b1;
          end
        end
      end
    end
  end

  assign bus.code       = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.is_break   = is_break_q;
  assign bus.is_ext     = is_ext_q;
  assign bus.history    = history_q;
  assign bus.entries    = entries_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.timeout    = timeout_q;
  assign bus.err_sticky = err_sticky_q;
endmodule

// File: tb/tb_ps2_scan_history.sv
// tb/tb_ps2_scan_history.sv - scoreboard bench for ps2_scan_history (keep and drop break modes)
module tb_ps2_scan_history;
  localparam int DEPTH = 8;
  localparam int FL    = 4;
  localparam int TMO   = 200;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ps2clk = 1'b1, ps2data = 1'b1, err_clr = 1'b0;

  always #5 CLK = ~CLK;

  ps2_scan_history_if #(.DEPTH(DEPTH)) bus0 ();
  ps2_scan_history_if #(.DEPTH(DEPTH)) bus1 ();

  assign bus0.ps2clk  = ps2clk;
  assign bus0.ps2data = ps2data;
  assign bus0.err_clr = err_clr;
  assign bus1.ps2clk  = ps2clk;
  assign bus1.ps2data = ps2data;
  assign bus1.err_clr = err_clr;

  ps2_scan_history #(.DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .DROP_BREAK(1'b0))
    u_dut  (.CLK(CLK), .RST(RST), .bus(bus0));
  ps2_scan_history #(.DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .DROP_BREAK(1'b1))
    u_drop (.CLK(CLK), .RST(RST), .bus(bus1));

  typedef struct packed {
    logic [7:0]  code;
    logic        brk;
    logic        ext;
    logic [63:0] hist;
    logic [3:0]  ent;
  } exp_t;

  exp_t        q0[$], q1[$];
  exp_t        e0, e1, em;
  logic [63:0] m_hist [2];
  logic [3:0]  m_ent  [2];
  logic        m_brk  [2];
  logic        m_ext  [2];
  int checks = 0, errors = 0;
  int ferr_cnt = 0, tmo_cnt = 0, exp_ferr = 0, exp_tmo = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus0.code_valid) begin
      check("dut0_strobe_expected", 64'(q0.size() > 0), 64'd1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("dut0_code", 64'(bus0.code), 64'(e0.code));
        check("dut0_break", 64'(bus0.is_break), 64'(e0.brk));
        check("dut0_ext", 64'(bus0.is_ext), 64'(e0.ext));
        check("dut0_history", bus0.history, e0.hist);
        check("dut0_entries", 64'(bus0.entries), 64'(e0.ent));
      end
    end
    if (bus1.code_valid) begin
      check("drop_strobe_expected", 64'(q1.size() > 0), 64'd1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("drop_code", 64'(bus1.code), 64'(e1.code));
        check("drop_break", 64'(bus1.is_break), 64'(e1.brk));
        check("drop_history", bus1.history, e1.hist);
      end
    end
    if (bus0.frame_err) ferr_cnt++;
    if (bus0.timeout) begin
      tmo_cnt++;
      check("timeout_with_frame_err", 64'(bus0.frame_err), 64'd1);
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hist[k] = '0; m_ent[k] = '0; m_brk[k] = 1'b0; m_ext[k] = 1'b0;
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_brk[k] = 1'b0; m_ext[k] = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    for (int k = 0; k < 2; k++) begin
      if (!good) begin
        m_brk[k] = 1'b0; m_ext[k] = 1'b0;
      end else if (b == 8'hE0) begin
        m_ext[k] = 1'b1;
      end else if (b == 8'hF0) begin
        m_brk[k] = 1'b1;
      end else begin
        if (!(k == 1 && m_brk[k])) begin
          m_hist[k] = {m_hist[k][55:0], b};
          if (m_ent[k] < DEPTH) m_ent[k] = m_ent[k] + 4'd1;
          em = '{code: b, brk: m_brk[k], ext: m_ext[k], hist: m_hist[k], ent: m_ent[k]};
          if (k == 0) q0.push_back(em);
          else        q1.push_back(em);
        end
        m_brk[k] = 1'b0; m_ext[k] = 1'b0;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge CLK) ps2data = b;
    repeat (10) @(negedge CLK);
    ps2clk = 1'b0;
    repeat (20) @(negedge CLK);
    ps2clk = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    model_frame(b, !bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask

  task automatic checkpoint(input string tag);
    repeat (30) @(negedge CLK);
    check({tag, "_q0_empty"}, 64'(q0.size()), 64'd0);
    check({tag, "_q1_empty"}, 64'(q1.size()), 64'd0);
    check({tag, "_hist0"}, bus0.history, m_hist[0]);
    check({tag, "_ent0"}, 64'(bus0.entries), 64'(m_ent[0]));
    check({tag, "_hist1"}, bus1.history, m_hist[1]);
    check({tag, "_ent1"}, 64'(bus1.entries), 64'(m_ent[1]));
    check({tag, "_ferr_cnt"}, 64'(ferr_cnt), 64'(exp_ferr));
    check({tag, "_tmo_cnt"}, 64'(tmo_cnt), 64'(exp_tmo));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_code"}, 64'(bus0.code), 64'd0);
    check({tag, "_valid"}, 64'(bus0.code_valid), 64'd0);
    check({tag, "_break"}, 64'(bus0.is_break), 64'd0);
    check({tag, "_ext"}, 64'(bus0.is_ext), 64'd0);
    check({tag, "_history"}, bus0.history, 64'd0);
    check({tag, "_entries"}, 64'(bus0.entries), 64'd0);
    check({tag, "_ferr"}, 64'(bus0.frame_err), 64'd0);
    check({tag, "_timeout"}, 64'(bus0.timeout), 64'd0);
    check({tag, "_sticky"}, 64'(bus0.err_sticky), 64'd0);
  endtask

  task automatic pulse_err_clr();
    @(negedge CLK) err_clr = 1'b1;
    @(negedge CLK) err_clr = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge CLK);
    check_idle_outputs("reset");
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    ps2clk = 1'b0;
    repeat (2) @(negedge CLK);
    ps2clk = 1'b1;
    repeat (20) @(negedge CLK);
    send_frame(8'h1C, 1'b0);
    checkpoint("clean");

    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    checkpoint("break");

    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'h29, 1'b0);
    checkpoint("ext_break");

    send_frame(8'h1C, 1'b1);
    exp_ferr++;
    checkpoint("parity");
    check("parity_sticky_set", 64'(bus0.err_sticky), 64'd1);
    pulse_err_clr();
    check("parity_sticky_clr", 64'(bus0.err_sticky), 64'd0);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (TMO + 100) @(negedge CLK);
    exp_ferr++;
    exp_tmo++;
    model_clear();
    checkpoint("timeout");
    check("timeout_sticky_set", 64'(bus0.err_sticky), 64'd1);
    pulse_err_clr();
    send_frame(8'h2A, 1'b0);
    checkpoint("after_timeout");
    check("after_timeout_code", 64'(bus0.code), 64'h2A);

    for (int i = 1; i <= 10; i++) send_frame(8'(i), 1'b0);
    checkpoint("depth");
    check("depth_history", bus0.history, 64'h030405060708090A);
    check("depth_entries", 64'(bus0.entries), 64'd8);

    @(negedge CLK) RST = 1'b1;
    @(negedge CLK);
    check_idle_outputs("final_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
